// File: rtl/sistema_final.sv
// sistema_final: ROM-driven 16-bit restoring divider demo; `SISTEMA_FINAL_DIVZERO_FLAG_EN adds the divZero flag output
module sistema_final #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] saida,
`ifdef SISTEMA_FINAL_DIVZERO_FLAG_EN
  output logic        divZero,
`endif
  output logic [15:0] saidaResto
);
  typedef enum logic [1:0] {LOAD, DIV, DONE, HOLD} state_t;
  state_t      state_q;
  logic [1:0]  idx_q;
  logic [15:0] quo_q, div_q, out_q, rest_q;
  logic [16:0] rem_q, rem_d;
  logic [3:0]  it_q;
  logic [7:0]  hold_q;
  logic [15:0] rom_dvd, rom_dvs;
  logic [17:0] trial_d;
  logic        ge_d;
`ifdef SISTEMA_FINAL_DIVZERO_FLAG_EN
  logic        zero_q;
  assign divZero = zero_q;
`endif
  assign saida      = out_q;
  assign saidaResto = rest_q;
  // operand ROM indexed by the entry counter
  always_comb begin
    rom_dvd = idx_q == 2'd0 ? 16'd100 : idx_q == 2'd1 ? 16'd65535 : idx_q == 2'd2 ? 16'd1234 : 16'd50;
    rom_dvs = idx_q == 2'd0 ? 16'd7   : idx_q == 2'd1 ? 16'd256   : idx_q == 2'd2 ? 16'd0    : 16'd50;
  end
  // one restoring step: shift in the next dividend bit, keep the difference when it does not go negative
  always_comb begin
    trial_d = {rem_q, quo_q[15]} - {2'b00, div_q};
    ge_d    = ~trial_d[17];
    rem_d   = ge_d ? trial_d[16:0] : {rem_q[15:0], quo_q[15]};
  end
  // control FSM with datapath registers and registered results
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= LOAD;
      idx_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      it_q    <= '0;
      hold_q  <= '0;
      out_q   <= '0;
      rest_q  <= '0;
`ifdef SISTEMA_FINAL_DIVZERO_FLAG_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        LOAD: begin
          quo_q   <= rom_dvd;
          div_q   <= rom_dvs;
          rem_q   <= '0;
          it_q    <= '0;
          state_q <= DIV;
        end
        DIV: begin
          quo_q   <= {quo_q[14:0], ge_d};
          rem_q   <= rem_d;
          it_q    <= it_q + 4'd1;
          state_q <= it_q == 4'd15 ? DONE : DIV;
        end
        DONE: begin
          out_q   <= quo_q;
          rest_q  <= rem_q[15:0];
          idx_q   <= idx_q + 2'd1;
          hold_q  <= '0;
          state_q <= HOLD_CYCLES == 0 ? LOAD : HOLD;
`ifdef SISTEMA_FINAL_DIVZERO_FLAG_EN
          zero_q  <= div_q == 16'd0;
`endif
        end
        HOLD: begin
          hold_q  <= hold_q + 8'd1;
          state_q <= hold_q == 8'(HOLD_CYCLES - 1) ? LOAD : HOLD;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sistema_final.sv
// tb_sistema_final: checks two divider instances (default hold and zero hold) against an edge-count result model
module tb_sistema_final;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] q4, r4, q0, r0;
  logic z4, z0;
  int n = 0;
  logic started = 1'b0;
  int cmp = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sistema_final #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .saida(q4),
`ifdef SISTEMA_FINAL_DIVZERO_FLAG_EN
    .divZero(z4),
`endif
    .saidaResto(r4));
  sistema_final #(.HOLD_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .saida(q0),
`ifdef SISTEMA_FINAL_DIVZERO_FLAG_EN
    .divZero(z0),
`endif
    .saidaResto(r0));
`ifndef SISTEMA_FINAL_DIVZERO_FLAG_EN
  assign z4 = 1'b0;
  assign z0 = 1'b0;
`endif

  // expected {divZero, quotient, remainder} after rising edge n since reset release
  function automatic logic [32:0] expect_at(int e, int h);
    int a, d, k;
    if (e < 18) return '0;
    k = ((e - 18) / (18 + h)) % 4;
    a = k == 0 ? 100 : k == 1 ? 65535 : k == 2 ? 1234 : 50;
    d = k == 0 ? 7 : k == 1 ? 256 : k == 2 ? 0 : 50;
    if (d == 0) return {1'b1, 16'hFFFF, 16'(a)};
    return {1'b0, 16'(a / d), 16'(a % d)};
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", nm, n, act, exp);
    end
  endtask

  always @(posedge clk) begin
    started = 1'b1;
    n = reset ? n + 1 : 0;
  end

  always @(negedge clk) begin
    if (started) begin
      logic [32:0] e4, e0;
      e4 = expect_at(n, 4);
      e0 = expect_at(n, 0);
      chk("h4_saida", q4, e4[31:16]);
      chk("h4_resto", r4, e4[15:0]);
      chk("h0_saida", q0, e0[31:16]);
      chk("h0_resto", r0, e0[15:0]);
`ifdef SISTEMA_FINAL_DIVZERO_FLAG_EN
      chk("h4_divzero", 16'(z4), 16'(e4[32]));
      chk("h0_divzero", 16'(z0), 16'(e0[32]));
`endif
    end
  end

  task automatic wait_n(int t);
    int g = 0;
    while (n < t) begin
      @(negedge clk);
      g++;
      if (g > 5000) begin
        cmp++;
        bad++;
        $display("FAIL wait_edge_%0d timed out at edge %0d", t, n);
        break;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_n(17); chk("lit17_q", q4, 16'd0);     chk("lit17_r", r4, 16'd0);
    wait_n(18); chk("lit18_q", q4, 16'd14);    chk("lit18_r", r4, 16'd2);
    wait_n(36); chk("h0_36_q", q0, 16'd255);   chk("h0_36_r", r0, 16'd255);
    wait_n(40); chk("lit40_q", q4, 16'd255);   chk("lit40_r", r4, 16'd255);
    wait_n(54); chk("h0_54_q", q0, 16'hFFFF);  chk("h0_54_r", r0, 16'd1234);
    wait_n(62); chk("lit62_q", q4, 16'hFFFF);  chk("lit62_r", r4, 16'd1234);
`ifdef SISTEMA_FINAL_DIVZERO_FLAG_EN
    chk("lit62_z", 16'(z4), 16'd1);
`endif
    wait_n(72); chk("h0_72_q", q0, 16'd1);     chk("h0_72_r", r0, 16'd0);
    wait_n(84); chk("lit84_q", q4, 16'd1);     chk("lit84_r", r4, 16'd0);
`ifdef SISTEMA_FINAL_DIVZERO_FLAG_EN
    chk("lit84_z", 16'(z4), 16'd0);
`endif
    wait_n(90); chk("h0_90_q", q0, 16'd14);    chk("h0_90_r", r0, 16'd2);
    wait_n(106); chk("lit106_q", q4, 16'd14);  chk("lit106_r", r4, 16'd2);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    wait_n(29);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_q", q4, 16'd0); chk("mid_rst_r", r4, 16'd0);
    chk("mid_rst_q0", q0, 16'd0);
    reset = 1'b1;
    wait_n(17); chk("post_rst17_q", q4, 16'd0);
    wait_n(18); chk("post_rst18_q", q4, 16'd14); chk("post_rst18_r", r4, 16'd2);
    for (int i = 0; i < 8; i++) begin
      reset = 1'b1;
      repeat ($urandom_range(5, 130)) @(negedge clk);
      reset = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    reset = 1'b1;
    wait_n(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
